// File: rtl/rice_core_decode_stage.sv
// Decode stage of the rice core: decodes LUI/ADDI/ADD/SUB into an ALU operation with operands,
// buffered in a 2-entry skid FIFO so the fetch-side ready can be a flop.
package rice_core_decode_pkg;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_command_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RS   = 2'd1,
        SRC_IMM  = 2'd2
    } alu_source_e;

    typedef struct packed {
        alu_command_e command;
        alu_source_e  source_1;
        alu_source_e  source_2;
    } rice_core_alu_operation;

endpackage

module rice_core_decode_stage
    import rice_core_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_if_valid,
    output logic                   o_if_ready,
    input  logic [31:0]            i_if_inst,
    output logic [4:0]             o_rs1_addr,
    output logic [4:0]             o_rs2_addr,
    input  logic [XLEN-1:0]        i_rs1_value,
    input  logic [XLEN-1:0]        i_rs2_value,
    output logic                   o_ex_valid,
    input  logic                   i_ex_ready,
    output rice_core_alu_operation o_ex_alu_operation,
    output logic [XLEN-1:0]        o_ex_rs1_value,
    output logic [XLEN-1:0]        o_ex_rs2_value,
    output logic [XLEN-1:0]        o_ex_imm_value,
    output logic [4:0]             o_ex_rd,
    output logic                   o_ex_rd_write,
    output logic                   o_ex_illegal
);

    typedef struct packed {
        rice_core_alu_operation op;
        logic [XLEN-1:0]        rs1_value;
        logic [XLEN-1:0]        rs2_value;
        logic [XLEN-1:0]        imm_value;
        logic [4:0]             rd;
        logic                   rd_write;
        logic                   illegal;
    } entry_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    entry_t            dec;
    logic              legal;
    logic signed [31:0] imm32;

    entry_t            entries [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;

    assign o_rs1_addr = i_if_inst[19:15];
    assign o_rs2_addr = i_if_inst[24:20];

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        legal     = 1'b0;
        imm32     = '0;
        dec       = '0;
        dec.op    = '{command: ALU_ADD, source_1: SRC_NONE, source_2: SRC_NONE};
        case (i_if_inst[6:0])
            OPC_LUI: begin
                legal           = 1'b1;
                dec.op.source_2 = SRC_IMM;
                imm32           = signed'({i_if_inst[31:12], 12'h000});
            end
            OPC_OP_IMM: begin
                if (i_if_inst[14:12] == 3'b000) begin
                    legal           = 1'b1;
                    dec.op.source_1 = SRC_RS;
                    dec.op.source_2 = SRC_IMM;
                    imm32           = signed'({{20{i_if_inst[31]}}, i_if_inst[31:20]});
                end
            end
            OPC_OP: begin
                if (i_if_inst[14:12] == 3'b000 &&
                    (i_if_inst[31:25] == 7'b0000000 || i_if_inst[31:25] == 7'b0100000)) begin
                    legal           = 1'b1;
                    dec.op.source_1 = SRC_RS;
                    dec.op.source_2 = SRC_RS;
                    dec.op.command  = i_if_inst[30] ? ALU_SUB : ALU_ADD;
                end
            end
            default: ;
        endcase
        dec.imm_value = XLEN'(imm32);
        dec.rs1_value = i_rs1_value;
        dec.rs2_value = i_rs2_value;
        dec.rd        = i_if_inst[11:7];
        dec.rd_write  = legal && (i_if_inst[11:7] != 5'd0);
        dec.illegal   = !legal;
    end

    assign push = i_if_valid && o_if_ready && !i_flush;
    assign pop  = o_ex_valid && i_ex_ready;

    always_comb begin
        count_next = count;
        if (i_flush) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    // NOTE: the entry storage is reset too, so the payload reads as a clean ADD/NONE/NONE out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            o_if_ready <= 1'b1;
        end else begin
            if (i_flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    entries[wr_ptr] <= dec;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
            count      <= count_next;
            o_if_ready <= (count_next < 2'd2);
        end
    end

    // Flush leaves entry data in place; o_ex_valid alone marks it dead.
    assign o_ex_valid         = (count != 2'd0);
    assign o_ex_alu_operation = entries[rd_ptr].op;
    assign o_ex_rs1_value     = entries[rd_ptr].rs1_value;
    assign o_ex_rs2_value     = entries[rd_ptr].rs2_value;
    assign o_ex_imm_value     = entries[rd_ptr].imm_value;
    assign o_ex_rd            = entries[rd_ptr].rd;
    assign o_ex_rd_write      = entries[rd_ptr].rd_write;
    assign o_ex_illegal       = entries[rd_ptr].illegal;

endmodule

// File: tb/tb_rice_core_decode_stage.sv
// Directed bench for rice_core_decode_stage: a queue-based model of decode + buffer checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_rice_core_decode_stage;
    import rice_core_decode_pkg::*;

    localparam int XLEN = 32;

    logic                   clk;
    logic                   rst;
    logic                   i_flush;
    logic                   i_if_valid;
    logic                   o_if_ready;
    logic [31:0]            i_if_inst;
    logic [4:0]             o_rs1_addr;
    logic [4:0]             o_rs2_addr;
    logic [XLEN-1:0]        i_rs1_value;
    logic [XLEN-1:0]        i_rs2_value;
    logic                   o_ex_valid;
    logic                   i_ex_ready;
    rice_core_alu_operation o_ex_alu_operation;
    logic [XLEN-1:0]        o_ex_rs1_value;
    logic [XLEN-1:0]        o_ex_rs2_value;
    logic [XLEN-1:0]        o_ex_imm_value;
    logic [4:0]             o_ex_rd;
    logic                   o_ex_rd_write;
    logic                   o_ex_illegal;

    rice_core_decode_stage #(.XLEN(XLEN)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_flush            (i_flush),
        .i_if_valid         (i_if_valid),
        .o_if_ready         (o_if_ready),
        .i_if_inst          (i_if_inst),
        .o_rs1_addr         (o_rs1_addr),
        .o_rs2_addr         (o_rs2_addr),
        .i_rs1_value        (i_rs1_value),
        .i_rs2_value        (i_rs2_value),
        .o_ex_valid         (o_ex_valid),
        .i_ex_ready         (i_ex_ready),
        .o_ex_alu_operation (o_ex_alu_operation),
        .o_ex_rs1_value     (o_ex_rs1_value),
        .o_ex_rs2_value     (o_ex_rs2_value),
        .o_ex_imm_value     (o_ex_imm_value),
        .o_ex_rd            (o_ex_rd),
        .o_ex_rd_write      (o_ex_rd_write),
        .o_ex_illegal       (o_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: x[i] = i * 0x01010101, x0 = 0.
    logic [XLEN-1:0] regs [32];
    assign i_rs1_value = regs[o_rs1_addr];
    assign i_rs2_value = regs[o_rs2_addr];

    typedef struct {
        rice_core_alu_operation op;
        logic [XLEN-1:0]        rs1;
        logic [XLEN-1:0]        rs2;
        logic [XLEN-1:0]        imm;
        logic [4:0]             rd;
        logic                   rd_write;
        logic                   illegal;
    } exp_t;

    exp_t exp_q [$];
    bit   m_ready = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level decode model using mask/match patterns.
    function automatic exp_t model_decode(input logic [31:0] inst);
        exp_t e;
        bit   legal = 1'b1;
        e.op       = '{command: ALU_ADD, source_1: SRC_NONE, source_2: SRC_NONE};
        e.imm      = '0;
        e.rs1      = regs[inst[19:15]];
        e.rs2      = regs[inst[24:20]];
        e.rd       = inst[11:7];
        if (inst[6:0] == 7'h37) begin
            e.op.source_2 = SRC_IMM;
            e.imm         = XLEN'($signed(inst & 32'hFFFF_F000));
        end else if ((inst & 32'h0000_707F) == 32'h0000_0013) begin
            e.op.source_1 = SRC_RS;
            e.op.source_2 = SRC_IMM;
            e.imm         = XLEN'($signed(inst) >>> 20);
        end else if ((inst & 32'hFE00_707F) == 32'h0000_0033) begin
            e.op.source_1 = SRC_RS;
            e.op.source_2 = SRC_RS;
        end else if ((inst & 32'hFE00_707F) == 32'h4000_0033) begin
            e.op.command  = ALU_SUB;
            e.op.source_1 = SRC_RS;
            e.op.source_2 = SRC_RS;
        end else begin
            legal = 1'b0;
        end
        e.illegal  = !legal;
        e.rd_write = legal && (inst[11:7] != 5'd0);
        return e;
    endfunction

    // Drive one cycle from a falling edge, advance the model on the rising edge, return at the next falling edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic exr, input logic fl);
        bit push;
        bit pop;
        i_if_valid = v;
        i_if_inst  = inst;
        i_ex_ready = exr;
        i_flush    = fl;
        #1;
        push = v && m_ready && !fl;
        pop  = (exp_q.size() != 0) && exr;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(model_decode(inst));
        end
        m_ready = (exp_q.size() < 2);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_if_valid = 1'b0;
        i_if_inst  = 32'h0;
        i_ex_ready = 1'b0;
        i_flush    = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("valid", 64'(o_ex_valid), 64'(exp_q.size() != 0));
        check("ready", 64'(o_if_ready), 64'(m_ready));
        if (exp_q.size() != 0) begin
            check("cmd",      64'(o_ex_alu_operation.command),  64'(exp_q[0].op.command));
            check("src1",     64'(o_ex_alu_operation.source_1), 64'(exp_q[0].op.source_1));
            check("src2",     64'(o_ex_alu_operation.source_2), 64'(exp_q[0].op.source_2));
            check("rs1_val",  64'(o_ex_rs1_value), 64'(exp_q[0].rs1));
            check("rs2_val",  64'(o_ex_rs2_value), 64'(exp_q[0].rs2));
            check("imm",      64'(o_ex_imm_value), 64'(exp_q[0].imm));
            check("rd",       64'(o_ex_rd),        64'(exp_q[0].rd));
            check("rd_write", 64'(o_ex_rd_write),  64'(exp_q[0].rd_write));
            check("illegal",  64'(o_ex_illegal),   64'(exp_q[0].illegal));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(o_ex_valid), 64'd0);
        check({tag, "_ready"}, 64'(o_if_ready), 64'd1);
        check({tag, "_op"},    64'(o_ex_alu_operation), 64'd0);
        check({tag, "_imm"},   64'(o_ex_imm_value), 64'd0);
        check({tag, "_rs1"},   64'(o_ex_rs1_value), 64'd0);
        check({tag, "_rd"},    64'(o_ex_rd), 64'd0);
        check({tag, "_wr"},    64'(o_ex_rd_write), 64'd0);
        check({tag, "_ill"},   64'(o_ex_illegal), 64'd0);
    endtask

    localparam logic [31:0] I_LUI1  = 32'h1234_50B7;  // lui  x1, 0x12345
    localparam logic [31:0] I_ADDI  = 32'hFFF0_8113;  // addi x2, x1, -1
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;  // add  x3, x1, x2
    localparam logic [31:0] I_SUB   = 32'h4020_8233;  // sub  x4, x1, x2
    localparam logic [31:0] I_A     = 32'h0070_0293;  // addi x5, x0, 7
    localparam logic [31:0] I_B     = 32'hABCD_E337;  // lui  x6, 0xABCDE
    localparam logic [31:0] I_C     = 32'h0041_83B3;  // add  x7, x3, x4
    localparam logic [31:0] I_NOP   = 32'h0000_0013;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = XLEN'(i) * XLEN'(32'h0101_0101);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;

        // 1: LUI after reset
        step(1'b1, I_LUI1, 1'b0, 1'b0);
        check("lui_valid", 64'(o_ex_valid), 64'd1);
        check("lui_imm",   64'(o_ex_imm_value), 64'h1234_5000);
        check("lui_src1",  64'(o_ex_alu_operation.source_1), 64'(SRC_NONE));
        check("lui_src2",  64'(o_ex_alu_operation.source_2), 64'(SRC_IMM));
        check("lui_cmd",   64'(o_ex_alu_operation.command), 64'(ALU_ADD));
        check("lui_rd",    64'(o_ex_rd), 64'd1);
        check("lui_wr",    64'(o_ex_rd_write), 64'd1);

        // 2: back-to-back stream, LUI pops as ADDI enters
        step(1'b1, I_ADDI, 1'b1, 1'b0);
        check("addi_imm",  64'(o_ex_imm_value), 64'hFFFF_FFFF);
        check("addi_rs1",  64'(o_ex_rs1_value), 64'h0101_0101);
        check("addi_rdy",  64'(o_if_ready), 64'd1);
        step(1'b1, I_ADD, 1'b1, 1'b0);
        check("add_cmd",   64'(o_ex_alu_operation.command), 64'(ALU_ADD));
        check("add_rs2",   64'(o_ex_rs2_value), 64'h0202_0202);
        check("add_rdy",   64'(o_if_ready), 64'd1);
        step(1'b1, I_SUB, 1'b1, 1'b0);
        check("sub_cmd",   64'(o_ex_alu_operation.command), 64'(ALU_SUB));
        check("sub_rd",    64'(o_ex_rd), 64'd4);
        check("sub_imm",   64'(o_ex_imm_value), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_valid", 64'(o_ex_valid), 64'd0);

        // 3: backpressure
        step(1'b1, I_A, 1'b0, 1'b0);
        check("bp1_rdy",   64'(o_if_ready), 64'd1);
        step(1'b1, I_B, 1'b0, 1'b0);
        check("bp2_rdy",   64'(o_if_ready), 64'd0);
        step(1'b1, I_C, 1'b0, 1'b0);
        step(1'b1, I_C, 1'b0, 1'b0);
        check("bp_head_rd",  64'(o_ex_rd), 64'd5);
        check("bp_head_imm", 64'(o_ex_imm_value), 64'd7);
        step(1'b1, I_C, 1'b1, 1'b0);   // pops A; C still refused this cycle
        check("bp_pop1_rd",  64'(o_ex_rd), 64'd6);
        check("bp_pop1_rdy", 64'(o_if_ready), 64'd1);
        step(1'b1, I_C, 1'b1, 1'b0);   // pops B, accepts C
        check("bp_pop2_rd",  64'(o_ex_rd), 64'd7);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_empty",    64'(o_ex_valid), 64'd0);

        // 4 and 5: illegal encodings and x0 destination
        step(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        check("ill0_ill",  64'(o_ex_illegal), 64'd1);
        check("ill0_wr",   64'(o_ex_rd_write), 64'd0);
        step(1'b1, 32'h0000_A033, 1'b1, 1'b0);
        check("ill1_ill",  64'(o_ex_illegal), 64'd1);
        check("ill1_src",  64'(o_ex_alu_operation), 64'd0);
        step(1'b1, 32'h2000_0033, 1'b1, 1'b0);
        check("ill2_ill",  64'(o_ex_illegal), 64'd1);
        check("ill2_wr",   64'(o_ex_rd_write), 64'd0);
        step(1'b1, 32'h0000_10B3, 1'b1, 1'b0);   // add-like with funct3 001, rd x1
        check("ill3_wr",   64'(o_ex_rd_write), 64'd0);
        step(1'b1, I_NOP, 1'b1, 1'b0);
        check("nop_ill",   64'(o_ex_illegal), 64'd0);
        check("nop_wr",    64'(o_ex_rd_write), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // 6: flush with two entries, then with one entry and an acceptable push
        step(1'b1, I_A, 1'b0, 1'b0);
        step(1'b1, I_B, 1'b0, 1'b0);
        step(1'b1, I_C, 1'b0, 1'b1);
        check("fl2_valid", 64'(o_ex_valid), 64'd0);
        check("fl2_rdy",   64'(o_if_ready), 64'd1);
        step(1'b1, I_A, 1'b0, 1'b0);
        step(1'b1, I_C, 1'b0, 1'b1);
        check("fl1_valid", 64'(o_ex_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("fl_nodeliver", 64'(o_ex_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // mid-stream asynchronous reset
        step(1'b1, I_LUI1, 1'b0, 1'b0);
        step(1'b1, I_B, 1'b0, 1'b0);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, I_SUB, 1'b0, 1'b0);
        check("post_rst_cmd", 64'(o_ex_alu_operation.command), 64'(ALU_SUB));
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
